// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole round controller.
//   state_e   : round FSM state encoding (also driven on the state port)
//   SCORE_MAX : score saturation value
//   COUNT_MAX : largest value the game timer can hold
package game_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned SCORE_W = 8;
   localparam int unsigned COUNT_W = 8;

   localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(255);
   localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(255);

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_OVER  = 3'd4
   } state_e;

endpackage

// File: rtl/sec_tick_gen.sv
// Game-second prescaler: counts 0..TICKS_PER_SEC-1 while enabled and flags
// the wrap cycle.
//   clk    : clock
//   reset  : async active-low reset
//   enable : advance the prescaler this cycle
//   clear  : synchronous return to 0 (wins over enable)
//   tick   : high in the enabled cycle where the prescaler wraps
module sec_tick_gen #(
   parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

   logic [CNT_W-1:0] cnt;

   // Tick is qualified by enable so a held prescaler never fires.
   assign tick = enable && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= tick ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/game_round_ctrl.sv
// Round controller: sequences IDLE/LOAD/RUN/PAUSE/OVER, paces the external
// game timer with one-second decrements, grants time bonuses and keeps score.
//   clk, reset           : clock, async active-low reset
//   start, pause         : one-cycle control pulses
//   hit_valid, hit_bonus : mole hit pulse and its time-bonus qualifier
//   count                : current game timer value (seconds)
//   timer_reset/inc/dec  : registered requests to the game timer
//   score                : saturating hit count for the round
//   mole_enable          : play active (RUN)
//   game_over            : round finished (OVER)
//   state                : current FSM state encoding
module game_round_ctrl
   import game_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 100_000_000,
   parameter int unsigned START_SECONDS = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               pause,
   input  logic               hit_valid,
   input  logic               hit_bonus,
   input  logic [COUNT_W-1:0] count,
   output logic               timer_reset,
   output logic               timer_inc,
   output logic               timer_dec,
   output logic [SCORE_W-1:0] score,
   output logic               mole_enable,
   output logic               game_over,
   output logic [STATE_W-1:0] state
);

   state_e             state_q, state_d;
   logic               timer_reset_d, timer_inc_d, timer_dec_d;
   logic               mole_enable_d, game_over_d;
   logic [SCORE_W-1:0] score_d;
   logic               stay_run, sec_tick, inc_req, dec_req;

   // Prescaler only advances in cycles that remain in RUN, so a pause or
   // end-of-round never swallows a pending second.
   assign stay_run = (state_q == ST_RUN) && (count != '0) && !pause;

   sec_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_sec_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .enable (stay_run),
      .clear  (state_q == ST_LOAD),
      .tick   (sec_tick)
   );

   // Next state and next registered outputs.
   always_comb begin
      state_d       = state_q;
      score_d       = score;
      timer_reset_d = 1'b0;
      timer_inc_d   = 1'b0;
      timer_dec_d   = 1'b0;
      mole_enable_d = 1'b0;
      game_over_d   = 1'b0;
      inc_req       = 1'b0;
      dec_req       = 1'b0;

      case (state_q)
         ST_IDLE:  if (start) state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_RUN;
         ST_RUN: begin
            if (count == '0)  state_d = ST_OVER;
            else if (pause)   state_d = ST_PAUSE;
         end
         ST_PAUSE: if (pause) state_d = ST_RUN;
         ST_OVER:  if (start) state_d = ST_LOAD;
         default:  state_d = ST_IDLE;
      endcase

      dec_req = stay_run && sec_tick;
      inc_req = stay_run && hit_valid && hit_bonus && (count != COUNT_MAX);
      // Bonus and decrement in the same cycle cancel out.
      timer_dec_d = dec_req && !inc_req;
      timer_inc_d = inc_req && !dec_req;

      if (state_d == ST_LOAD) begin
         score_d = '0;
      end else if ((state_q == ST_RUN) && hit_valid && (score != SCORE_MAX)) begin
         score_d = score + SCORE_W'(1);
      end

      timer_reset_d = (state_d == ST_LOAD);
      mole_enable_d = (state_d == ST_RUN);
      game_over_d   = (state_d == ST_OVER);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         score       <= '0;
         timer_reset <= 1'b0;
         timer_inc   <= 1'b0;
         timer_dec   <= 1'b0;
         mole_enable <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         state_q     <= state_d;
         score       <= score_d;
         timer_reset <= timer_reset_d;
         timer_inc   <= timer_inc_d;
         timer_dec   <= timer_dec_d;
         mole_enable <= mole_enable_d;
         game_over   <= game_over_d;
      end
   end

   assign state = state_q;

   // A reload request must be reflected by the game timer one cycle later.
   a_reload: assert property (@(posedge clk) disable iff (!reset)
      timer_reset |=> (count == COUNT_W'(START_SECONDS)));

endmodule

// File: tb/tb_game_round_ctrl.sv
module tb_game_round_ctrl;

   localparam int unsigned TPS   = 4;
   localparam int unsigned START = 20;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_PAUSE = 3'd3;
   localparam logic [2:0] S_OVER  = 3'd4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       hit_valid = 1'b0;
   logic       hit_bonus = 1'b0;
   logic [7:0] count = 8'd0;
   logic       timer_reset, timer_inc, timer_dec;
   logic [7:0] score;
   logic       mole_enable, game_over;
   logic [2:0] state;

   int n_checks = 0;
   int n_pass   = 0;

   game_round_ctrl #(.TICKS_PER_SEC(TPS), .START_SECONDS(START)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .pause       (pause),
      .hit_valid   (hit_valid),
      .hit_bonus   (hit_bonus),
      .count       (count),
      .timer_reset (timer_reset),
      .timer_inc   (timer_inc),
      .timer_dec   (timer_dec),
      .score       (score),
      .mole_enable (mole_enable),
      .game_over   (game_over),
      .state       (state)
   );

   always #5 clk = ~clk;

   // Paired game timer: reload, saturating increment/decrement; not reset.
   always @(posedge clk) begin
      if (timer_reset)                       count <= 8'(START);
      else if (timer_inc && count != 8'd255) count <= count + 8'd1;
      else if (timer_dec && count != 8'd0)   count <= count - 8'd1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   initial begin
      int k, ndec, last, n255;
      logic [7:0] cnt_seen;

      // Reset state
      step(); step();
      chk("rst_state", state, S_IDLE);
      chk("rst_score", score, 0);
      chk("rst_treset", timer_reset, 0);
      chk("rst_inc", timer_inc, 0);
      chk("rst_dec", timer_dec, 0);
      chk("rst_mole", mole_enable, 0);
      chk("rst_over", game_over, 0);

      // Release reset, start -> LOAD for one cycle -> RUN
      reset = 1'b1;
      step();
      chk("idle_after_release", state, S_IDLE);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("load_state", state, S_LOAD);
      chk("load_treset", timer_reset, 1);
      chk("load_score", score, 0);
      step();
      chk("run_state", state, S_RUN);
      chk("run_treset", timer_reset, 0);
      chk("run_mole", mole_enable, 1);
      chk("run_count", count, 20);
      chk("run_score", score, 0);

      // Undisturbed round: 20 decrements spaced 4 cycles, then OVER
      k = 1; ndec = 0; last = 0;
      while (state == S_RUN && k < 200) begin
         if (timer_dec) begin
            ndec++;
            if (ndec == 1) chk("first_dec_cycle", k, 5);
            else           chk("dec_spacing", k - last, 4);
            last = k;
         end
         chk("no_inc_idle_round", timer_inc, 0);
         step();
         k++;
      end
      chk("over_cycle", k, 83);
      chk("dec_total", ndec, 20);
      chk("over_state", state, S_OVER);
      chk("over_flag", game_over, 1);
      chk("over_mole", mole_enable, 0);
      chk("over_count", count, 0);
      chk("over_dec", timer_dec, 0);

      // OVER -> LOAD -> RUN
      start = 1'b1;
      step();
      start = 1'b0;
      chk("reload_state", state, S_LOAD);
      chk("reload_treset", timer_reset, 1);
      step();
      chk("rerun_count", count, 20);
      // k=1: start ignored in RUN
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_ignored", state, S_RUN);
      step();
      step();
      // k=4 is a sec_tick cycle: bonus hit cancels the decrement
      hit_valid = 1'b1; hit_bonus = 1'b1;
      step();
      hit_valid = 1'b0; hit_bonus = 1'b0;
      chk("tick_bonus_inc", timer_inc, 0);
      chk("tick_bonus_dec", timer_dec, 0);
      chk("tick_bonus_score", score, 1);
      step();
      chk("tick_bonus_count", count, 20);
      // k=6: bonus hit off a tick -> increment
      hit_valid = 1'b1; hit_bonus = 1'b1;
      step();
      hit_valid = 1'b0; hit_bonus = 1'b0;
      chk("bonus_inc", timer_inc, 1);
      chk("bonus_score", score, 2);
      step();
      chk("bonus_count", count, 21);
      chk("bonus_inc_pulse", timer_inc, 0);
      step();
      chk("k9_dec", timer_dec, 1);
      step();
      chk("k10_count", count, 20);
      step();
      // k=11, prescaler=2: pause
      pause = 1'b1;
      step();
      pause = 1'b0;
      chk("pause_state", state, S_PAUSE);
      chk("pause_mole", mole_enable, 0);
      for (int i = 0; i < 10; i++) begin
         hit_valid = (i == 5);
         step();
         chk("pause_no_dec", timer_dec, 0);
         chk("pause_hold", state, S_PAUSE);
      end
      hit_valid = 1'b0;
      pause = 1'b1;
      step();
      pause = 1'b0;
      chk("resume_state", state, S_RUN);
      chk("resume_dec_r1", timer_dec, 0);
      step();
      chk("resume_dec_r2", timer_dec, 0);
      step();
      chk("resume_dec_r3", timer_dec, 1);
      step();
      chk("resume_count", count, 19);
      chk("pause_hit_ignored", score, 2);

      // Long bonus-hit stream: score saturates, no bonus at count==255
      n255 = 0;
      for (int i = 0; i < 450; i++) begin
         hit_valid = 1'b1; hit_bonus = 1'b1;
         cnt_seen = count;
         step();
         if (cnt_seen == 8'd255) begin
            n255++;
            chk("no_inc_at_255", timer_inc, 0);
         end
         chk("inc_dec_excl", int'(timer_inc & timer_dec), 0);
         if (i == 299) chk("score_sat_300", score, 255);
      end
      hit_valid = 1'b0; hit_bonus = 1'b0;
      chk("count_255_seen", int'(n255 > 0), 1);
      chk("score_sat_end", score, 255);
      chk("stream_state", state, S_RUN);

      // Async reset mid-RUN
      reset = 1'b0;
      #2;
      chk("async_state", state, S_IDLE);
      chk("async_score", score, 0);
      chk("async_mole", mole_enable, 0);
      chk("async_over", game_over, 0);
      chk("async_inc", timer_inc, 0);
      chk("async_dec", timer_dec, 0);
      chk("async_treset", timer_reset, 0);
      reset = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("post_rst_load", state, S_LOAD);
      step();
      chk("post_rst_run", state, S_RUN);
      chk("post_rst_count", count, 20);
      chk("post_rst_score", score, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100_000_000, clk cycles per game second.
REQ-002 SHALL have parameter START_SECONDS, default 20, value game_timer_counter loads on timer_reset; used only by checkers.
REQ-003 SHALL have port clk  input  1  the only clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse from the debounced start button.
REQ-006 SHALL have port pause  input  1  one-cycle pulse; toggles pause.
REQ-007 SHALL have port hit_valid  input  1  one-cycle pulse; a mole was hit.
REQ-008 SHALL have port hit_bonus  input  1  qualifies hit_valid as a time-bonus hit; ignored without hit_valid.
REQ-009 SHALL have port count  input  8  current game timer value, seconds.
REQ-010 SHALL have port timer_reset  output  1  reload request to the game timer.
REQ-011 SHALL have port timer_inc  output  1  one-cycle increment request to the game timer.
REQ-012 SHALL have port timer_dec  output  1  one-cycle decrement request to the game timer.
REQ-013 SHALL have port score  output  8  hits this round.
REQ-014 SHALL have port mole_enable  output  1  high only while play is active.
REQ-015 SHALL have port game_over  output  1  high while in OVER.
REQ-016 SHALL have port state  output  3  current FSM state encoding.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RUN, PAUSE, OVER.
REQ-018 SHALL transition IDLE->LOAD on start and OVER->LOAD on start; start SHALL be ignored in LOAD, RUN and PAUSE.
REQ-019 SHALL spend exactly one cycle in LOAD, driving timer_reset=1, clearing score and the prescaler, then enter RUN.
REQ-020 SHALL, in RUN, advance a prescaler 0..TICKS_PER_SEC-1, wrapping to 0, and raise an internal sec_tick on the wrap cycle.
REQ-021 SHALL assert timer_dec for one cycle on sec_tick when count!=0.
REQ-022 SHALL assert timer_inc for one cycle when hit_valid&hit_bonus in RUN and count!=255; at count==255 the bonus is dropped.
REQ-023 SHALL assert neither timer_inc nor timer_dec when both qualify in the same cycle (net zero).
REQ-024 SHALL never assert timer_inc and timer_dec together, and SHALL assert neither outside RUN.
REQ-025 SHALL increment score on every hit_valid in RUN, saturating at 255; hits outside RUN are ignored.
REQ-026 SHALL transition RUN->OVER on the first cycle count==0 is sampled in RUN; pause in that cycle is ignored.
REQ-027 SHALL toggle RUN<->PAUSE on pause; in PAUSE the prescaler and score hold, and sec_tick is suppressed.
REQ-028 SHALL drive mole_enable=1 only in RUN; game_over=1 only in OVER; score held in OVER until next LOAD.
REQ-029 SHALL register all outputs (no combinational input-to-output path).

Reset
REQ-030 SHALL, on reset low, enter IDLE immediately: prescaler=0, score=0, timer_reset=0, timer_inc=0, timer_dec=0, mole_enable=0, game_over=0.
REQ-031 SHALL, on reset mid-round (RUN/PAUSE), abandon the round; the game timer is reloaded only via the next LOAD.

Structure
REQ-032 SHALL take the state enumeration and the SCORE_MAX=255 and COUNT_MAX=255 constants from shared package game_pkg.
REQ-033 SHALL place the prescaler in sub-module sec_tick_gen (ports clk, reset, enable, clear, tick).

Verification (TICKS_PER_SEC=4, paired with game_timer_counter)
REQ-034 SHALL verify: reset release, start pulse -> one-cycle LOAD with timer_reset=1, then RUN; count=20, score=0.
REQ-035 SHALL verify: RUN for 80 cycles, no hits -> 20 timer_dec pulses spaced 4 cycles; count reaches 0; OVER; game_over=1; mole_enable=0.
REQ-036 SHALL verify: bonus hit on a sec_tick cycle -> no inc/dec that cycle; count unchanged; score +1.
REQ-037 SHALL verify: pause at prescaler=2, hold 10 cycles, pause again -> no timer_dec during PAUSE; next timer_dec 2 cycles after resume.
REQ-038 SHALL verify: 300 hit_valid pulses in RUN -> score saturates at 255; bonus hit with count=255 -> timer_inc stays 0.
REQ-039 SHALL verify: reset low mid-RUN -> IDLE asynchronously, all outputs 0; start -> LOAD reloads count to 20.
